// File: rtl/sd_regs_pkg.sv
// Register offsets, STATUS bit positions and fixed register widths shared by the
// SD register file and its sub-modules.
package sd_regs_pkg;

    localparam logic [6:0] AddrArg     = 7'h00;
    localparam logic [6:0] AddrCmd     = 7'h04;
    localparam logic [6:0] AddrResp0   = 7'h08;
    localparam logic [6:0] AddrResp1   = 7'h0C;
    localparam logic [6:0] AddrResp2   = 7'h10;
    localparam logic [6:0] AddrResp3   = 7'h14;
    localparam logic [6:0] AddrCtrl    = 7'h18;
    localparam logic [6:0] AddrBlksize = 7'h1C;
    localparam logic [6:0] AddrVoltage = 7'h20;
    localparam logic [6:0] AddrReset   = 7'h24;
    localparam logic [6:0] AddrCmdTmo  = 7'h28;
    localparam logic [6:0] AddrDataTmo = 7'h2C;
    localparam logic [6:0] AddrCmdIsr  = 7'h30;
    localparam logic [6:0] AddrCmdIer  = 7'h34;
    localparam logic [6:0] AddrClkdiv  = 7'h38;
    localparam logic [6:0] AddrCapa    = 7'h3C;
    localparam logic [6:0] AddrDataIsr = 7'h40;
    localparam logic [6:0] AddrDataIer = 7'h44;
    localparam logic [6:0] AddrBlkcnt  = 7'h48;
    localparam logic [6:0] AddrStatus  = 7'h4C;

    localparam int unsigned StatusStartBit   = 0;
    localparam int unsigned StatusCmdRstBit  = 1;
    localparam int unsigned StatusDataRstBit = 2;

    localparam int unsigned CtrlW   = 16;
    localparam int unsigned ResetW  = 1;
    localparam int unsigned ClkdivW = 8;

endpackage

// File: rtl/sd_byte_reg.sv
// Writable register of arbitrary width updated one byte lane at a time from the host bus.
// Bytes that fall outside the register width are silently dropped.
module sd_byte_reg #(
    parameter int unsigned BUS_W = 8,
    parameter int unsigned W     = 8,
    parameter logic [31:0] RST   = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr,
    input  logic [BUS_W/8-1:0] be,
    input  logic [1:0]         b0,
    input  logic [BUS_W-1:0]   data,
    output logic [W-1:0]       q
);

    localparam int NB = int'(BUS_W / 8);

    logic [W-1:0] q_d;

    // Lane k lands on register byte b0+k.
    always_comb begin
        q_d = q;
        for (int i = 0; i < int'(W); i++) begin
            for (int k = 0; k < NB; k++) begin
                if (wr && be[k] && (int'(b0) + k == i / 8)) begin
                    q_d[i] = data[k * 8 + i % 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST[W-1:0];
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/sd_pulse_stretch.sv
// Holds a request pending until the next rising edge of the divided SD clock.
// The output also covers the setting cycle itself.
module sd_pulse_stretch (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic sd_edge,
    output logic pending,
    output logic pulse
);

    logic pending_d;

    // A set arriving on the same cycle as an edge keeps the request alive.
    always_comb begin
        pending_d = pending;
        if (set) begin
            pending_d = 1'b1;
        end else if (sd_edge) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
        end else begin
            pending <= pending_d;
        end
    end

    assign pulse = pending | set;

endmodule

// File: rtl/sd_regfile_bus.sv
// Host-bus register file for the SD controller: byte-lane writes, registered reads,
// masked interrupt request and SD-clock-stretched command/interrupt-reset pulses.
module sd_regfile_bus
    import sd_regs_pkg::*;
#(
    parameter int unsigned BUS_W          = 8,
    parameter int unsigned CMD_W          = 14,
    parameter int unsigned CMD_TIMEOUT_W  = 24,
    parameter int unsigned DATA_TIMEOUT_W = 24,
    parameter int unsigned BLKSIZE_W      = 12,
    parameter int unsigned BLKCNT_W       = 16,
    parameter int unsigned INT_CMD_W      = 5,
    parameter int unsigned INT_DATA_W     = 3,
    parameter int unsigned RESET_BLKSIZE  = 512,
    parameter int unsigned VOLTAGE_MV     = 3300,
    parameter logic [15:0] CAPA           = 16'h0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sd_clk,
    input  logic                      we,
    input  logic                      re,
    input  logic [6:0]                addr,
    input  logic [BUS_W/8-1:0]        be,
    input  logic [BUS_W-1:0]          data_in,
    output logic [BUS_W-1:0]          data_out,
    output logic                      rd_valid,
    output logic                      wr_err,
    output logic                      cmd_start,
    output logic                      cmd_int_rst,
    output logic                      data_int_rst,
    output logic [31:0]               argument_reg,
    output logic [CMD_W-1:0]          command_reg,
    output logic [ResetW-1:0]         software_reset_reg,
    output logic [CMD_TIMEOUT_W-1:0]  cmd_timeout_reg,
    output logic [DATA_TIMEOUT_W-1:0] data_timeout_reg,
    output logic [BLKSIZE_W-1:0]      block_size_reg,
    output logic [CtrlW-1:0]          controll_setting_reg,
    output logic [ClkdivW-1:0]        clock_divider_reg,
    output logic [BLKCNT_W-1:0]       block_count_reg,
    input  logic [31:0]               response_0_reg,
    input  logic [31:0]               response_1_reg,
    input  logic [31:0]               response_2_reg,
    input  logic [31:0]               response_3_reg,
    input  logic [INT_CMD_W-1:0]      cmd_int_status_reg,
    input  logic [INT_DATA_W-1:0]     data_int_status_reg,
    output logic                      irq
);

    localparam int NB = int'(BUS_W / 8);

    logic [6:0]            reg_sel;
    logic [1:0]            b0;
    logic                  byte0_en;
    logic                  sd_prev;
    logic                  sd_edge;
    logic                  start_pending, cmd_rst_pending, data_rst_pending;
    logic                  start_set, cmd_rst_set, data_rst_set;
    logic                  busy_hit;
    logic                  wr_arg, wr_cmd, wr_ctrl, wr_blksize, wr_reset, wr_cmd_tmo;
    logic                  wr_data_tmo, wr_cmd_ier, wr_clkdiv, wr_data_ier, wr_blkcnt;
    logic [INT_CMD_W-1:0]  cmd_ier;
    logic [INT_DATA_W-1:0] data_ier;
    logic [31:0]           rd_word;
    logic [BUS_W-1:0]      rd_lanes;

    assign reg_sel  = addr & 7'h7C;
    assign b0       = addr[1:0] & ~2'(NB - 1);
    assign byte0_en = (b0 == 2'd0) && be[0];
    assign sd_edge  = sd_clk & ~sd_prev;

    // ARG/CMD are frozen while a command start is still waiting for the SD clock.
    assign busy_hit  = we && start_pending && (reg_sel == AddrArg || reg_sel == AddrCmd);
    assign start_set = we && !start_pending && (reg_sel == AddrArg) && byte0_en;
    assign cmd_rst_set  = we && (reg_sel == AddrCmdIsr) && byte0_en;
    assign data_rst_set = we && (reg_sel == AddrDataIsr) && byte0_en;

    assign wr_arg      = we && !start_pending && (reg_sel == AddrArg);
    assign wr_cmd      = we && !start_pending && (reg_sel == AddrCmd);
    assign wr_ctrl     = we && (reg_sel == AddrCtrl);
    assign wr_blksize  = we && (reg_sel == AddrBlksize);
    assign wr_reset    = we && (reg_sel == AddrReset);
    assign wr_cmd_tmo  = we && (reg_sel == AddrCmdTmo);
    assign wr_data_tmo = we && (reg_sel == AddrDataTmo);
    assign wr_cmd_ier  = we && (reg_sel == AddrCmdIer);
    assign wr_clkdiv   = we && (reg_sel == AddrClkdiv);
    assign wr_data_ier = we && (reg_sel == AddrDataIer);
    assign wr_blkcnt   = we && (reg_sel == AddrBlkcnt);

    sd_byte_reg #(.BUS_W(BUS_W), .W(32), .RST(32'd0)) u_arg (
        .clk(clk), .rst(rst), .wr(wr_arg), .be(be), .b0(b0), .data(data_in), .q(argument_reg));
    sd_byte_reg #(.BUS_W(BUS_W), .W(CMD_W), .RST(32'd0)) u_cmd (
        .clk(clk), .rst(rst), .wr(wr_cmd), .be(be), .b0(b0), .data(data_in), .q(command_reg));
    sd_byte_reg #(.BUS_W(BUS_W), .W(CtrlW), .RST(32'd0)) u_ctrl (
        .clk(clk), .rst(rst), .wr(wr_ctrl), .be(be), .b0(b0), .data(data_in),
        .q(controll_setting_reg));
    sd_byte_reg #(.BUS_W(BUS_W), .W(BLKSIZE_W), .RST(32'(RESET_BLKSIZE))) u_blksize (
        .clk(clk), .rst(rst), .wr(wr_blksize), .be(be), .b0(b0), .data(data_in),
        .q(block_size_reg));
    sd_byte_reg #(.BUS_W(BUS_W), .W(ResetW), .RST(32'd0)) u_reset (
        .clk(clk), .rst(rst), .wr(wr_reset), .be(be), .b0(b0), .data(data_in),
        .q(software_reset_reg));
    sd_byte_reg #(.BUS_W(BUS_W), .W(CMD_TIMEOUT_W), .RST(32'd0)) u_cmd_tmo (
        .clk(clk), .rst(rst), .wr(wr_cmd_tmo), .be(be), .b0(b0), .data(data_in),
        .q(cmd_timeout_reg));
    sd_byte_reg #(.BUS_W(BUS_W), .W(DATA_TIMEOUT_W), .RST(32'd0)) u_data_tmo (
        .clk(clk), .rst(rst), .wr(wr_data_tmo), .be(be), .b0(b0), .data(data_in),
        .q(data_timeout_reg));
    sd_byte_reg #(.BUS_W(BUS_W), .W(INT_CMD_W), .RST(32'd0)) u_cmd_ier (
        .clk(clk), .rst(rst), .wr(wr_cmd_ier), .be(be), .b0(b0), .data(data_in), .q(cmd_ier));
    sd_byte_reg #(.BUS_W(BUS_W), .W(ClkdivW), .RST(32'd1)) u_clkdiv (
        .clk(clk), .rst(rst), .wr(wr_clkdiv), .be(be), .b0(b0), .data(data_in),
        .q(clock_divider_reg));
    sd_byte_reg #(.BUS_W(BUS_W), .W(INT_DATA_W), .RST(32'd0)) u_data_ier (
        .clk(clk), .rst(rst), .wr(wr_data_ier), .be(be), .b0(b0), .data(data_in), .q(data_ier));
    sd_byte_reg #(.BUS_W(BUS_W), .W(BLKCNT_W), .RST(32'd0)) u_blkcnt (
        .clk(clk), .rst(rst), .wr(wr_blkcnt), .be(be), .b0(b0), .data(data_in),
        .q(block_count_reg));

    sd_pulse_stretch u_start (
        .clk(clk), .rst(rst), .set(start_set), .sd_edge(sd_edge),
        .pending(start_pending), .pulse(cmd_start));
    sd_pulse_stretch u_cmd_rst (
        .clk(clk), .rst(rst), .set(cmd_rst_set), .sd_edge(sd_edge),
        .pending(cmd_rst_pending), .pulse(cmd_int_rst));
    sd_pulse_stretch u_data_rst (
        .clk(clk), .rst(rst), .set(data_rst_set), .sd_edge(sd_edge),
        .pending(data_rst_pending), .pulse(data_int_rst));

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            AddrArg:     rd_word = argument_reg;
            AddrCmd:     rd_word = 32'(command_reg);
            AddrResp0:   rd_word = response_0_reg;
            AddrResp1:   rd_word = response_1_reg;
            AddrResp2:   rd_word = response_2_reg;
            AddrResp3:   rd_word = response_3_reg;
            AddrCtrl:    rd_word = 32'(controll_setting_reg);
            AddrBlksize: rd_word = 32'(block_size_reg);
            AddrVoltage: rd_word = 32'(VOLTAGE_MV);
            AddrReset:   rd_word = 32'(software_reset_reg);
            AddrCmdTmo:  rd_word = 32'(cmd_timeout_reg);
            AddrDataTmo: rd_word = 32'(data_timeout_reg);
            AddrCmdIsr:  rd_word = 32'(cmd_int_status_reg);
            AddrCmdIer:  rd_word = 32'(cmd_ier);
            AddrClkdiv:  rd_word = 32'(clock_divider_reg);
            AddrCapa:    rd_word = 32'(CAPA);
            AddrDataIsr: rd_word = 32'(data_int_status_reg);
            AddrDataIer: rd_word = 32'(data_ier);
            AddrBlkcnt:  rd_word = 32'(block_count_reg);
            AddrStatus: begin
                rd_word[StatusStartBit]   = start_pending;
                rd_word[StatusCmdRstBit]  = cmd_rst_pending;
                rd_word[StatusDataRstBit] = data_rst_pending;
            end
            default:     rd_word = '0;
        endcase
        rd_lanes = '0;
        for (int k = 0; k < NB; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (int'(b0) + k == j) begin
                    rd_lanes[k*8 +: 8] = rd_word[j*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sd_prev  <= 1'b0;
            wr_err   <= 1'b0;
            irq      <= 1'b0;
            rd_valid <= 1'b0;
            data_out <= '0;
        end else begin
            sd_prev  <= sd_clk;
            wr_err   <= busy_hit;
            irq      <= (|(cmd_int_status_reg & cmd_ier)) || (|(data_int_status_reg & data_ier));
            rd_valid <= re;
            if (re) begin
                data_out <= rd_lanes;
            end
        end
    end

endmodule

// File: tb/tb_sd_regfile_bus.sv
// Directed bench for sd_regfile_bus: three bus widths (8/16/32) sharing one clock,
// address/data/strobe stimulus and the divided SD clock; each has its own write strobe.
module tb_sd_regfile_bus;

    logic        clk;
    logic        rst;
    logic        sd_clk;
    logic        re;
    logic        we8, we16, we32;
    logic [6:0]  addr;
    logic [3:0]  be;
    logic [31:0] din;
    logic [4:0]  cmd_st;
    logic [2:0]  data_st;

    logic [7:0]  dout8;
    logic [15:0] dout16;
    logic [31:0] dout32;
    logic        rdv [3];
    logic        werr [3];
    logic        cst [3];
    logic        cir [3];
    logic        dir [3];
    logic        irq [3];
    logic [31:0] arg [3];
    logic [13:0] cmd [3];
    logic [0:0]  swr [3];
    logic [23:0] ctmo [3];
    logic [23:0] dtmo [3];
    logic [11:0] bsz [3];
    logic [15:0] ctrl [3];
    logic [7:0]  cdiv [3];
    logic [15:0] bcnt [3];

    int n_cmp = 0;
    int n_bad = 0;

    sd_regfile_bus #(.BUS_W(8)) u8 (
        .clk(clk), .rst(rst), .sd_clk(sd_clk), .we(we8), .re(re), .addr(addr),
        .be(be[0:0]), .data_in(din[7:0]), .data_out(dout8), .rd_valid(rdv[0]),
        .wr_err(werr[0]), .cmd_start(cst[0]), .cmd_int_rst(cir[0]), .data_int_rst(dir[0]),
        .argument_reg(arg[0]), .command_reg(cmd[0]), .software_reset_reg(swr[0]),
        .cmd_timeout_reg(ctmo[0]), .data_timeout_reg(dtmo[0]), .block_size_reg(bsz[0]),
        .controll_setting_reg(ctrl[0]), .clock_divider_reg(cdiv[0]),
        .block_count_reg(bcnt[0]), .response_0_reg(32'hA5A5_0001),
        .response_1_reg(32'hA5A5_0002), .response_2_reg(32'hA5A5_0003),
        .response_3_reg(32'hA5A5_0004), .cmd_int_status_reg(cmd_st),
        .data_int_status_reg(data_st), .irq(irq[0]));

    sd_regfile_bus #(.BUS_W(16)) u16 (
        .clk(clk), .rst(rst), .sd_clk(sd_clk), .we(we16), .re(re), .addr(addr),
        .be(be[1:0]), .data_in(din[15:0]), .data_out(dout16), .rd_valid(rdv[1]),
        .wr_err(werr[1]), .cmd_start(cst[1]), .cmd_int_rst(cir[1]), .data_int_rst(dir[1]),
        .argument_reg(arg[1]), .command_reg(cmd[1]), .software_reset_reg(swr[1]),
        .cmd_timeout_reg(ctmo[1]), .data_timeout_reg(dtmo[1]), .block_size_reg(bsz[1]),
        .controll_setting_reg(ctrl[1]), .clock_divider_reg(cdiv[1]),
        .block_count_reg(bcnt[1]), .response_0_reg(32'hA5A5_0001),
        .response_1_reg(32'hA5A5_0002), .response_2_reg(32'hA5A5_0003),
        .response_3_reg(32'hA5A5_0004), .cmd_int_status_reg(cmd_st),
        .data_int_status_reg(data_st), .irq(irq[1]));

    sd_regfile_bus #(.BUS_W(32)) u32 (
        .clk(clk), .rst(rst), .sd_clk(sd_clk), .we(we32), .re(re), .addr(addr),
        .be(be), .data_in(din), .data_out(dout32), .rd_valid(rdv[2]),
        .wr_err(werr[2]), .cmd_start(cst[2]), .cmd_int_rst(cir[2]), .data_int_rst(dir[2]),
        .argument_reg(arg[2]), .command_reg(cmd[2]), .software_reset_reg(swr[2]),
        .cmd_timeout_reg(ctmo[2]), .data_timeout_reg(dtmo[2]), .block_size_reg(bsz[2]),
        .controll_setting_reg(ctrl[2]), .clock_divider_reg(cdiv[2]),
        .block_count_reg(bcnt[2]), .response_0_reg(32'hA5A5_0001),
        .response_1_reg(32'hA5A5_0002), .response_2_reg(32'hA5A5_0003),
        .response_3_reg(32'hA5A5_0004), .cmd_int_status_reg(cmd_st),
        .data_int_status_reg(data_st), .irq(irq[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we8 = 1'b0; we16 = 1'b0; we32 = 1'b0; re = 1'b0;
    endtask

    task automatic wr(input int sel, input logic [6:0] a, input logic [3:0] b,
                      input logic [31:0] d);
        addr = a; be = b; din = d;
        we8 = (sel == 8); we16 = (sel == 16); we32 = (sel == 32);
    endtask

    task automatic rd(input logic [6:0] a);
        addr = a; re = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; sd_clk = 1'b0; idle();
        addr = '0; be = '0; din = '0; cmd_st = '0; data_st = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        chk("rst_cmd_start", 32'(cst[1]), 0);
        chk("rst_wr_err", 32'(werr[1]), 0);
        chk("rst_irq", 32'(irq[1]), 0);
        chk("rst_rd_valid", 32'(rdv[1]), 0);
        chk("rst_data_out", 32'(dout16), 0);
        chk("rst_clkdiv8", 32'(cdiv[0]), 1);
        chk("rst_clkdiv16", 32'(cdiv[1]), 1);
        chk("rst_blksize", 32'(bsz[1]), 512);
        chk("rst_arg", arg[2], 0);

        // 8-bit bus: assemble ARG byte by byte, byte 0 last so it alone starts.
        wr(8, 7'h03, 4'h1, 32'h12); #1;
        chk("b8_no_start", 32'(cst[0]), 0);
        tick(); wr(8, 7'h02, 4'h1, 32'h34);
        tick(); wr(8, 7'h01, 4'h1, 32'h56);
        tick(); wr(8, 7'h00, 4'h1, 32'h78); #1;
        chk("b8_start_comb", 32'(cst[0]), 1);
        tick(); idle();
        chk("b8_arg", arg[0], 32'h1234_5678);
        chk("b8_start_held", 32'(cst[0]), 1);
        tick(); tick();
        chk("b8_start_wait", 32'(cst[0]), 1);
        sd_clk = 1'b1; #1;
        chk("b8_start_edge_cyc", 32'(cst[0]), 1);
        tick(); sd_clk = 1'b0;
        chk("b8_start_fall", 32'(cst[0]), 0);

        // 32-bit bus: writes to ARG/CMD are refused while the start is pending.
        tick();
        wr(32, 7'h00, 4'hF, 32'hCAFE_F00D);
        tick(); idle();
        chk("b32_arg", arg[2], 32'hCAFE_F00D);
        chk("b32_start", 32'(cst[2]), 1);
        wr(32, 7'h04, 4'hF, 32'h1234);
        tick(); idle();
        chk("b32_werr_cmd", 32'(werr[2]), 1);
        chk("b32_cmd_kept", 32'(cmd[2]), 0);
        wr(32, 7'h00, 4'hF, 32'h1111_1111);
        tick(); idle();
        chk("b32_werr_arg", 32'(werr[2]), 1);
        chk("b32_arg_kept", arg[2], 32'hCAFE_F00D);
        tick();
        chk("b32_werr_drop", 32'(werr[2]), 0);
        sd_clk = 1'b1;
        tick(); sd_clk = 1'b0;
        chk("b32_start_fall", 32'(cst[2]), 0);
        wr(32, 7'h04, 4'hF, 32'h1234);
        tick(); idle();
        chk("b32_cmd_retry", 32'(cmd[2]), 32'h1234);
        chk("b32_no_werr", 32'(werr[2]), 0);
        rd(7'h08);
        tick(); idle();
        chk("b32_resp0", dout32, 32'hA5A5_0001);
        chk("b32_rd_valid", 32'(rdv[2]), 1);

        // VOLTAGE reads across bus widths and lane offsets.
        rd(7'h22);
        tick(); idle();
        chk("volt22_valid", 32'(rdv[1]), 1);
        chk("volt22_b16", 32'(dout16), 0);
        chk("volt22_b8", 32'(dout8), 0);
        chk("volt22_b32", dout32, 32'h0CE4);
        tick();
        chk("rd_valid_drop", 32'(rdv[1]), 0);
        chk("dout_hold", dout32, 32'h0CE4);
        rd(7'h21);
        tick(); idle();
        chk("volt21_b8", 32'(dout8), 32'h0C);
        chk("volt21_b16", 32'(dout16), 32'h0CE4);
        rd(7'h20);
        tick(); idle();
        chk("volt20_b16", 32'(dout16), 32'h0CE4);
        chk("volt20_b8", 32'(dout8), 32'hE4);

        // Interrupt masking and ISR reset pulses on the 16-bit bus.
        cmd_st = 5'h02;
        wr(16, 7'h34, 4'h1, 32'h01);
        tick(); idle();
        tick();
        chk("irq_masked", 32'(irq[1]), 0);
        cmd_st = 5'h03; #1;
        chk("irq_latency", 32'(irq[1]), 0);
        tick();
        chk("irq_set", 32'(irq[1]), 1);
        chk("irq_other_ier0", 32'(irq[2]), 0);
        wr(16, 7'h30, 4'h1, 32'h00); #1;
        chk("cmd_rst_comb", 32'(cir[1]), 1);
        tick(); idle();
        chk("cmd_rst_held", 32'(cir[1]), 1);
        rd(7'h4C);
        tick(); idle();
        chk("status_rd", 32'(dout16), 32'h0002);
        sd_clk = 1'b1;
        tick(); sd_clk = 1'b0;
        chk("cmd_rst_fall", 32'(cir[1]), 0);
        cmd_st = 5'h00;
        tick();
        chk("irq_clear", 32'(irq[1]), 0);
        data_st = 3'h4;
        wr(16, 7'h44, 4'h1, 32'h04);
        tick(); idle();
        tick();
        chk("irq_data", 32'(irq[1]), 1);
        data_st = 3'h0;
        wr(16, 7'h40, 4'h1, 32'h00);
        tick(); idle();
        chk("data_rst", 32'(dir[1]), 1);
        chk("irq_data_clear", 32'(irq[1]), 0);

        // Lane boundaries: bytes beyond BLKSIZE width and unmapped offsets.
        wr(16, 7'h1E, 4'h3, 32'hFFFF);
        tick(); idle();
        chk("blksize_hi_drop", 32'(bsz[1]), 512);
        wr(16, 7'h1C, 4'h2, 32'hFF00);
        tick(); idle();
        chk("blksize_lane1", 32'(bsz[1]), 32'hF00);
        wr(16, 7'h50, 4'h3, 32'hFFFF);
        tick(); idle();
        rd(7'h50);
        tick(); idle();
        chk("unmapped_rd", 32'(dout16), 0);

        // Reset while a start is pending.
        wr(16, 7'h38, 4'h1, 32'h05);
        tick(); idle();
        chk("clkdiv_wr", 32'(cdiv[1]), 5);
        wr(16, 7'h00, 4'h3, 32'hBEEF);
        tick(); idle();
        chk("b16_start", 32'(cst[1]), 1);
        chk("b16_arg", arg[1], 32'hBEEF);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("midrst_start", 32'(cst[1]), 0);
        chk("midrst_clkdiv", 32'(cdiv[1]), 1);
        chk("midrst_blksize", 32'(bsz[1]), 512);
        chk("midrst_arg", arg[1], 0);
        chk("midrst_data_rst", 32'(dir[1]), 0);

        // Same-cycle write and read returns the old value.
        wr(16, 7'h1C, 4'h3, 32'h0040);
        re = 1'b1;
        tick(); idle();
        chk("rw_old", 32'(dout16), 32'h0200);
        chk("rw_new_reg", 32'(bsz[1]), 32'h040);
        rd(7'h1C);
        tick(); idle();
        chk("rw_reread", 32'(dout16), 32'h0040);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
